// File: rtl/alu_exec_unit.sv
// Integer ALU functional unit: computes one op per cycle and holds the result until the CDB accepts it.
// Define ALU_SKID_BUF_EN to add a one-entry skid register and a registered issue_ready.
package alu_ops_pkg;
  typedef enum logic [3:0] {
    noALU   = 4'd0,
    addALU  = 4'd1,
    subALU  = 4'd2,
    xorALU  = 4'd3,
    orALU   = 4'd4,
    andALU  = 4'd5,
    sllALU  = 4'd6,
    srlALU  = 4'd7,
    sraALU  = 4'd8,
    sltALU  = 4'd9,
    sltuALU = 4'd10,
    luiALU  = 4'd11
  } ALU_operation_t;
endpackage

module alu_exec_unit
  import alu_ops_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  ALU_operation_t   issue_op,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_result,
  output logic             cdb_zero
);

  logic [31:0]      alu_result;
  logic [4:0]       shamt;
  logic             issue_fire;
  logic             drain;

  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      out_result;
  logic             out_zero;

  assign shamt = issue_b[4:0];

  // NOTE: combinational blocks assign a default first so no path leaves the output unassigned (no latch).
  always_comb begin
    alu_result = 32'd0;
    case (issue_op)
      addALU:  alu_result = issue_a + issue_b;
      subALU:  alu_result = issue_a - issue_b;
      xorALU:  alu_result = issue_a ^ issue_b;
      orALU:   alu_result = issue_a | issue_b;
      andALU:  alu_result = issue_a & issue_b;
      sllALU:  alu_result = issue_a << shamt;
      srlALU:  alu_result = issue_a >> shamt;
      sraALU:  alu_result = $unsigned($signed(issue_a) >>> shamt);
      sltALU:  alu_result = {31'd0, $signed(issue_a) < $signed(issue_b)};
      sltuALU: alu_result = {31'd0, issue_a < issue_b};
      luiALU:  alu_result = issue_b;
      default: alu_result = 32'd0;
    endcase
  end

  assign issue_fire = issue_valid && issue_ready;
  assign drain      = out_valid && cdb_ready;

`ifdef ALU_SKID_BUF_EN
  logic             skid_valid;
  logic [TAG_W-1:0] skid_tag;
  logic [31:0]      skid_result;

  assign issue_ready = !skid_valid;

  // The skid entry is only filled while the output is stalled, so it always drains into the output first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_tag     <= '0;
      out_result  <= 32'd0;
      out_zero    <= 1'b1;
      skid_valid  <= 1'b0;
      skid_tag    <= '0;
      skid_result <= 32'd0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (drain) begin
        out_tag    <= skid_tag;
        out_result <= skid_result;
        out_zero   <= (skid_result == 32'd0);
        skid_valid <= 1'b0;
      end
    end else if (issue_fire) begin
      if (!out_valid || drain) begin
        out_valid  <= 1'b1;
        out_tag    <= issue_tag;
        out_result <= alu_result;
        out_zero   <= (alu_result == 32'd0);
      end else begin
        skid_valid  <= 1'b1;
        skid_tag    <= issue_tag;
        skid_result <= alu_result;
      end
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end
`else
  // Combinational from cdb_ready: a draining output frees the slot in the same cycle.
  assign issue_ready = !out_valid || cdb_ready;

  // NOTE: sequential state uses non-blocking assignments; the data registers are reset too because
  // cdb_tag/cdb_result/cdb_zero have defined reset values, not just the valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_tag    <= '0;
      out_result <= 32'd0;
      out_zero   <= 1'b1;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue_fire) begin
      out_valid  <= 1'b1;
      out_tag    <= issue_tag;
      out_result <= alu_result;
      out_zero   <= (alu_result == 32'd0);
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign cdb_valid  = out_valid;
  assign cdb_tag    = out_tag;
  assign cdb_result = out_result;
  assign cdb_zero   = out_zero;

endmodule
